sd_fifo_head_sw: RTL

SD_FIFO_HEAD_SW -- requirements
Module: sd_fifo_head_sw

---
 rtl/sd_fifo_head_sw.sv | 105 ++++++++++
 1 files changed

// File: rtl/sd_fifo_head_sw.sv
// sd_fifo_head_sw: write-side head of a split FIFO with optional commit/abort.
// Optional feature macro: SDLIB_FIFO_HEAD_COMMIT_EN. When it is defined,
// c_commit publishes written words and c_abort rolls them back. When it is
// undefined, every write is published on the next enabled edge.
// Pointers are asz+1 bits wide; the extra MSB tells full apart from empty.
module sd_fifo_head_sw #(
   parameter int depth = 16,
   parameter int async = 0,
   parameter int asz   = $clog2(depth)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           clken,
   input  logic           c_srdy,
   output logic           c_drdy,
   input  logic           c_commit,
   input  logic           c_abort,
   output logic [asz:0]   wrptr_head,
   input  logic [asz:0]   rdptr_tail,
   output logic           wr_en,
   output logic [asz-1:0] wr_addr,
   output logic [asz:0]   c_usage
);

   logic [asz:0] rdptr;
   logic [asz:0] wrptr_q, wrptr_d;
   logic [asz:0] cptr_q, cptr_d;
   logic [asz:0] nxt_wrptr;
   logic         full;

   function automatic logic [asz:0] grey2bin(input logic [asz:0] g);
      logic [asz:0] b;
      b[asz] = g[asz];
      for (int i = asz - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [asz:0] bin2grey(input logic [asz:0] b);
      return b ^ (b >> 1);
   endfunction

   generate
      if (async != 0) begin : g_rd_grey
         assign rdptr = grey2bin(rdptr_tail);
      end else begin : g_rd_bin
         assign rdptr = rdptr_tail;
      end
   endgenerate

   assign full      = (wrptr_q[asz] != rdptr[asz]) && (wrptr_q[asz-1:0] == rdptr[asz-1:0]);
   assign c_drdy    = ~full;
   assign wr_en     = clken & c_srdy & c_drdy;
   assign wr_addr   = wrptr_q[asz-1:0];
   assign nxt_wrptr = wr_en ? wrptr_q + 1'b1 : wrptr_q;
   assign c_usage   = wrptr_q - rdptr;

`ifdef SDLIB_FIFO_HEAD_COMMIT_EN
   // Next working/committed pointers: abort rolls back and wins over commit.
   always_comb begin
      wrptr_d = nxt_wrptr;
      cptr_d  = cptr_q;
      if (clken && c_abort) begin
         wrptr_d = cptr_q;
      end else if (clken && c_commit) begin
         cptr_d = nxt_wrptr;
      end
   end
`else
   logic unused_ctl;
   assign unused_ctl = c_commit ^ c_abort;

   // Next pointers: every enabled cycle publishes the working pointer.
   always_comb begin
      wrptr_d = nxt_wrptr;
      cptr_d  = cptr_q;
      if (clken) cptr_d = nxt_wrptr;
   end
`endif

   // Pointer registers; async reset discards committed and uncommitted words.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrptr_q <= '0;
         cptr_q  <= '0;
      end else if (clken) begin
         wrptr_q <= wrptr_d;
         cptr_q  <= cptr_d;
      end
   end

   generate
      if (async != 0) begin : g_head_grey
         logic [asz:0] head_q;
         // Gray head is registered so the crossing sees one bit change per step.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) head_q <= '0;
            else if (clken) head_q <= bin2grey(cptr_d);
         end
         assign wrptr_head = head_q;
      end else begin : g_head_bin
         assign wrptr_head = cptr_q;
      end
   endgenerate

endmodule
